// File: rtl/fp_addsub.sv
// Multi-cycle IEEE-style floating-point adder/subtractor (subnormals flushed, RNE).
// Fixed 4-cycle latency: ALIGN, ADD, NORM, ROUND; specials resolved at capture.
module fp_addsub #(
  parameter int EXP = 8,
  parameter int MAN = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [EXP+MAN:0] a,
  input  logic [EXP+MAN:0] b,
  output logic [EXP+MAN:0] out,
  output logic             valid,
  output logic             busy,
  output logic             overflow,
  output logic             invalid
);

  localparam int W  = EXP + MAN + 1;
  localparam int SW = MAN + 4;            // hidden + mantissa + guard/round/sticky
  localparam int LW = $clog2(SW + 1);
  localparam int EW = EXP + LW + 1;       // signed working exponent

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND} state_t;

  state_t          r_state;
  logic [W-1:0]    r_a, r_b;
  logic            r_op;
  logic            r_spec, r_spec_inv;
  logic [W-1:0]    r_spec_out;
  logic [SW-1:0]   r_sig_l, r_sig_s, r_norm;
  logic [SW:0]     r_sum;
  logic [EW-1:0]   r_exp;
  logic            r_sign, r_sub, r_zero;

  // Special-case detection on the live inputs at capture time
  logic [EXP-1:0]  w_ea_in, w_eb_in;
  logic [MAN-1:0]  w_ma_in, w_mb_in;
  logic            w_sa_in, w_sb_in;
  logic            w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
  logic            w_spec, w_spec_inv;
  logic [W-1:0]    w_spec_out;

  assign w_sa_in  = a[W-1];
  assign w_sb_in  = b[W-1] ^ op;
  assign w_ea_in  = a[W-2:MAN];
  assign w_eb_in  = b[W-2:MAN];
  assign w_ma_in  = a[MAN-1:0];
  assign w_mb_in  = b[MAN-1:0];
  assign w_nan_a  = (&w_ea_in) & (|w_ma_in);
  assign w_nan_b  = (&w_eb_in) & (|w_mb_in);
  assign w_inf_a  = (&w_ea_in) & ~(|w_ma_in);
  assign w_inf_b  = (&w_eb_in) & ~(|w_mb_in);
  assign w_zero_a = ~(|w_ea_in);
  assign w_zero_b = ~(|w_eb_in);

  always_comb begin
    w_spec     = 1'b0;
    w_spec_inv = 1'b0;
    w_spec_out = '0;
    if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sa_in != w_sb_in))) begin
      w_spec                = 1'b1;
      w_spec_inv            = 1'b1;
      w_spec_out[W-2:MAN]   = '1;
      w_spec_out[MAN-1]     = 1'b1;
    end else if (w_inf_a) begin
      w_spec     = 1'b1;
      w_spec_out = a;
    end else if (w_inf_b) begin
      w_spec              = 1'b1;
      w_spec_out[W-1]     = w_sb_in;
      w_spec_out[W-2:MAN] = '1;
    end else if (w_zero_a && w_zero_b) begin
      w_spec          = 1'b1;
      w_spec_out[W-1] = w_sa_in & w_sb_in;
    end
  end

  // ALIGN: order by magnitude and right-shift the smaller significand
  logic [EXP-1:0]  w_ea, w_eb, w_exp_l, w_exp_s, w_diff;
  logic [W-2:0]    w_mag_a, w_mag_b;
  logic            w_sa, w_sb, w_swap;
  logic [SW-1:0]   w_sig_a, w_sig_b, w_sig_l, w_sig_raw, w_sig_s;

  assign w_ea      = r_a[W-2:MAN];
  assign w_eb      = r_b[W-2:MAN];
  assign w_sa      = r_a[W-1];
  assign w_sb      = r_b[W-1] ^ r_op;
  assign w_mag_a   = (w_ea == '0) ? '0 : r_a[W-2:0];
  assign w_mag_b   = (w_eb == '0) ? '0 : r_b[W-2:0];
  assign w_sig_a   = (w_ea == '0) ? '0 : {1'b1, r_a[MAN-1:0], 3'b000};
  assign w_sig_b   = (w_eb == '0) ? '0 : {1'b1, r_b[MAN-1:0], 3'b000};
  assign w_swap    = w_mag_b > w_mag_a;
  assign w_exp_l   = w_swap ? w_eb : w_ea;
  assign w_exp_s   = w_swap ? w_ea : w_eb;
  assign w_sig_l   = w_swap ? w_sig_b : w_sig_a;
  assign w_sig_raw = w_swap ? w_sig_a : w_sig_b;
  assign w_diff    = w_exp_l - w_exp_s;

  always_comb begin
    w_sig_s = '0;
    if (32'(w_diff) >= 32'(MAN + 3)) begin
      w_sig_s[0] = |w_sig_raw;
    end else begin
      w_sig_s    = w_sig_raw >> w_diff;
      w_sig_s[0] = w_sig_s[0] | (|(w_sig_raw & ~({SW{1'b1}} << w_diff)));
    end
  end

  // NORM: leading-zero count of the non-carry sum
  logic [LW-1:0]   w_lzc;
  logic            w_found;

  always_comb begin
    w_lzc   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < SW; i++) begin
      if (!w_found && r_sum[SW-1-i]) begin
        w_lzc   = LW'(i);
        w_found = 1'b1;
      end
    end
  end

  // ROUND: round-to-nearest-even, then underflow/overflow resolution
  logic            w_rup, w_uflow, w_oflow;
  logic [MAN+1:0]  w_rmant;
  logic [EW-1:0]   w_rexp;
  logic [W-1:0]    w_res;
  logic            w_res_ov, w_res_inv;

  assign w_rup   = r_norm[2] & (r_norm[1] | r_norm[0] | r_norm[3]);
  assign w_rmant = {1'b0, r_norm[SW-1:3]} + (MAN+2)'(w_rup);
  assign w_rexp  = r_exp + EW'(w_rmant[MAN+1]);
  assign w_uflow = r_exp[EW-1] | (r_exp == '0);
  assign w_oflow = w_rexp >= EW'({EXP{1'b1}});

  always_comb begin
    w_res     = '0;
    w_res_ov  = 1'b0;
    w_res_inv = 1'b0;
    if (r_spec) begin
      w_res     = r_spec_out;
      w_res_inv = r_spec_inv;
    end else if (r_zero) begin
      w_res = '0;
    end else if (w_uflow) begin
      w_res[W-1] = r_sign;
    end else if (w_oflow) begin
      w_res[W-1]     = r_sign;
      w_res[W-2:MAN] = '1;
      w_res_ov       = 1'b1;
    end else begin
      w_res = {r_sign, w_rexp[EXP-1:0], w_rmant[MAN-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= 1'b0;
      r_spec     <= 1'b0;
      r_spec_inv <= 1'b0;
      r_spec_out <= '0;
      r_sig_l    <= '0;
      r_sig_s    <= '0;
      r_sum      <= '0;
      r_norm     <= '0;
      r_exp      <= '0;
      r_sign     <= 1'b0;
      r_sub      <= 1'b0;
      r_zero     <= 1'b0;
      out        <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      invalid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a        <= a;
            r_b        <= b;
            r_op       <= op;
            r_spec     <= w_spec;
            r_spec_out <= w_spec_out;
            r_spec_inv <= w_spec_inv;
            busy       <= 1'b1;
            r_state    <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          r_sig_l <= w_sig_l;
          r_sig_s <= w_sig_s;
          r_exp   <= EW'(w_exp_l);
          r_sign  <= w_swap ? w_sb : w_sa;
          r_sub   <= w_sa ^ w_sb;
          r_state <= S_ADD;
        end
        S_ADD: begin
          r_sum   <= r_sub ? ({1'b0, r_sig_l} - {1'b0, r_sig_s})
                           : ({1'b0, r_sig_l} + {1'b0, r_sig_s});
          r_state <= S_NORM;
        end
        S_NORM: begin
          if (r_sum[SW]) begin
            r_norm <= {r_sum[SW:2], r_sum[1] | r_sum[0]};
            r_exp  <= r_exp + EW'(1);
          end else begin
            r_norm <= r_sum[SW-1:0] << w_lzc;
            r_exp  <= r_exp - EW'(w_lzc);
          end
          r_zero  <= (r_sum == '0);
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          out      <= w_res;
          overflow <= w_res_ov;
          invalid  <= w_res_inv;
          valid    <= 1'b1;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub.sv
// Bench for fp_addsub: directed vector table, protocol sequences and random
// regression of two instances (8/23 and 5/10) against an exact-arithmetic model.
module tb_fp_addsub;

  typedef logic [511:0] big_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] y;
    logic        ov;
    logic        inv;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, op8, op5;
  logic [31:0] a8, b8, out8;
  logic [15:0] a5, b5, out5;
  logic        valid8, busy8, ov8, inv8;
  logic        valid5, busy5, ov5, inv5;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_addsub #(.EXP(8), .MAN(23)) u8 (
    .clk(clk), .rst(rst), .start(start), .op(op8), .a(a8), .b(b8),
    .out(out8), .valid(valid8), .busy(busy8), .overflow(ov8), .invalid(inv8)
  );

  fp_addsub #(.EXP(5), .MAN(10)) u5 (
    .clk(clk), .rst(rst), .start(start), .op(op5), .a(a5), .b(b5),
    .out(out5), .valid(valid5), .busy(busy5), .overflow(ov5), .invalid(inv5)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Exact reference: operands become integers scaled to the smallest normal
  // exponent, are added exactly, then rounded to nearest-even.
  function automatic void model(input int E, input int M, input logic [31:0] a,
                                input logic [31:0] b, input logic op,
                                output logic [31:0] res, output logic ov, output logic inv);
    int W, emax, ea, eb, p, e, sh;
    logic [31:0] mmask, ma, mb, qnan;
    logic sa, sb, sr, nan_a, nan_b, inf_a, inf_b;
    big_t one, va, vb, mag, q, rem, half;
    W     = E + M + 1;
    emax  = (1 << E) - 1;
    mmask = (32'd1 << M) - 1;
    sa    = a[W-1];
    sb    = b[W-1] ^ op;
    ea    = int'((a >> M) & 32'(emax));
    eb    = int'((b >> M) & 32'(emax));
    ma    = a & mmask;
    mb    = b & mmask;
    qnan  = (32'(emax) << M) | (32'd1 << (M - 1));
    nan_a = (ea == emax) && (ma != 0);
    nan_b = (eb == emax) && (mb != 0);
    inf_a = (ea == emax) && (ma == 0);
    inf_b = (eb == emax) && (mb == 0);
    res = '0; ov = 1'b0; inv = 1'b0; one = 1; sr = 1'b0;
    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin res = qnan; inv = 1'b1; return; end
    if (inf_a) begin res = a; return; end
    if (inf_b) begin res = (32'(sb) << (W - 1)) | (32'(emax) << M); return; end
    if (ea == 0 && eb == 0) begin res = 32'(sa & sb) << (W - 1); return; end
    va = '0; vb = '0;
    if (ea != 0) begin va[31:0] = ma | (32'd1 << M); va = va << (ea - 1); end
    if (eb != 0) begin vb[31:0] = mb | (32'd1 << M); vb = vb << (eb - 1); end
    if (sa == sb) begin mag = va + vb; sr = sa; end
    else if (va >= vb) begin mag = va - vb; sr = sa; end
    else begin mag = vb - va; sr = sb; end
    if (mag == 0) begin res = '0; return; end
    p = 0;
    for (int i = 511; i >= 0; i--) if (mag[i]) begin p = i; break; end
    e = p - M + 1;
    if (e <= 0) begin res = 32'(sr) << (W - 1); return; end
    sh = p - M;
    q  = mag;
    if (sh > 0) begin
      q    = mag >> sh;
      rem  = mag & ((one << sh) - one);
      half = one << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + one;
    end
    if (q == (one << (M + 1))) begin q = q >> 1; e++; end
    if (e >= emax) begin res = (32'(sr) << (W - 1)) | (32'(emax) << M); ov = 1'b1; return; end
    res = (32'(sr) << (W - 1)) | (32'(e) << M) | (q[31:0] & mmask);
  endfunction

  function automatic logic [31:0] rnd_fp(input int E, input int M);
    int emax, r;
    logic [31:0] s, e, m;
    emax = (1 << E) - 1;
    s = 32'($urandom_range(0, 1));
    m = $urandom & ((32'd1 << M) - 1);
    r = $urandom_range(0, 15);
    if (r == 0)      e = 0;
    else if (r == 1) begin e = 32'(emax); if ($urandom_range(0, 1) == 0) m = 0; end
    else if (r == 2) e = 32'(emax - 1);
    else if (r == 3) e = 1;
    else if (r < 10) e = 32'($urandom_range(emax / 2 - 3, emax / 2 + 3));
    else             e = 32'($urandom_range(1, emax - 1));
    return (s << (E + M)) | (e << M) | m;
  endfunction

  function automatic logic [31:0] rnd_pair(input int E, input int M, input logic [31:0] x);
    if ($urandom_range(0, 3) == 0)
      return x ^ 32'($urandom_range(0, 3)) ^ (32'($urandom_range(0, 1)) << (E + M));
    return rnd_fp(E, M);
  endfunction

  // Called at a negedge; returns at the negedge after the valid cycle.
  task automatic do_op(input string tag, input logic [31:0] ia8, input logic [31:0] ib8,
                       input logic iop8, input logic [31:0] e8, input logic eov8,
                       input logic einv8, input logic [15:0] ia5, input logic [15:0] ib5,
                       input logic iop5);
    logic [31:0] e5;
    logic        eo5, ei5;
    int          k;
    model(5, 10, {16'h0, ia5}, {16'h0, ib5}, iop5, e5, eo5, ei5);
    a8 = ia8; b8 = ib8; op8 = iop8;
    a5 = ia5; b5 = ib5; op5 = iop5;
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    a8 = $urandom; b8 = $urandom; op8 = ~iop8;
    a5 = 16'($urandom); b5 = 16'($urandom); op5 = ~iop5;
    chk({tag, " busy"}, 64'(busy8), 64'd1);
    k = 0;
    while (!valid8 && k < 10) begin @(posedge clk); @(negedge clk); k++; end
    chk({tag, " latency"}, 64'(k), 64'd4);
    chk({tag, " out8"}, 64'(out8), 64'(e8));
    chk({tag, " ov8"}, 64'(ov8), 64'(eov8));
    chk({tag, " inv8"}, 64'(inv8), 64'(einv8));
    chk({tag, " valid5"}, 64'(valid5), 64'd1);
    chk({tag, " out5"}, 64'(out5), 64'(e5[15:0]));
    chk({tag, " ov5"}, 64'(ov5), 64'(eo5));
    chk({tag, " inv5"}, 64'(inv5), 64'(ei5));
    @(negedge clk);
    chk({tag, " valid pulse"}, 64'(valid8), 64'd0);
  endtask

  vec_t        tv[20];
  logic [31:0] ra, rb, e8, x5;
  logic        eo, ei, rop, seen;

  initial begin
    tv[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0};
    tv[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0};
    tv[2]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    tv[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0};
    tv[4]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b1};
    tv[5]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1};
    tv[6]  = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0, 1'b0};
    tv[7]  = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 1'b0};
    tv[8]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0};
    tv[9]  = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b0};
    tv[10] = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    tv[11] = '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    tv[12] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0};
    tv[13] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0};
    tv[14] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 1'b0, 1'b0};
    tv[15] = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 1'b0, 1'b0};
    tv[16] = '{32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 1'b1, 1'b0};
    tv[17] = '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    tv[18] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 1'b0, 1'b0};
    tv[19] = '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0;
    a8 = '0; b8 = '0; op8 = 1'b0; a5 = '0; b5 = '0; op5 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out8", 64'(out8), 64'd0);
    chk("reset valid8", 64'(valid8), 64'd0);
    chk("reset busy8", 64'(busy8), 64'd0);
    chk("reset flags8", 64'({ov8, inv8}), 64'd0);
    chk("reset out5", 64'(out5), 64'd0);
    chk("reset valid5/busy5", 64'({valid5, busy5}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++)
      do_op($sformatf("vec%0d", i), tv[i].a, tv[i].b, tv[i].op, tv[i].y, tv[i].ov, tv[i].inv,
            16'($urandom), 16'($urandom), 1'($urandom));

    // start held high: second pair presented while busy must wait for the IDLE slot
    a8 = 32'h3F800000; b8 = 32'h40000000; op8 = 1'b0;
    a5 = 16'h3C00; b5 = 16'h3C00; op5 = 1'b0;
    start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(posedge clk);
      @(negedge clk);
      chk($sformatf("held busy[%0d]", i), 64'(busy8), 64'((i % 5) != 4));
      chk($sformatf("held valid[%0d]", i), 64'(valid8), 64'((i % 5) == 4));
      if (i == 0) begin a8 = 32'h40400000; b8 = 32'h3F800000; op8 = 1'b1; end
      if (i == 4) chk("held result1", 64'(out8), 64'h40400000);
      if (i == 9) begin chk("held result2", 64'(out8), 64'h40000000); start = 1'b0; end
    end
    @(posedge clk); @(negedge clk);
    chk("held idle busy", 64'(busy8), 64'd0);
    chk("held idle valid", 64'(valid8), 64'd0);

    // reset at each in-flight stage aborts the operation
    for (int s = 1; s <= 4; s++) begin
      do_op($sformatf("pre-rst%0d", s), 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0,
            16'h7BFF, 16'h7BFF, 1'b0);
      a8 = 32'h3F800000; b8 = 32'h40000000; op8 = 1'b0;
      start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      repeat (s - 1) begin @(posedge clk); @(negedge clk); end
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      chk($sformatf("rst%0d out8", s), 64'(out8), 64'd0);
      chk($sformatf("rst%0d flags8", s), 64'({ov8, inv8}), 64'd0);
      chk($sformatf("rst%0d busy/valid", s), 64'({busy8, valid8}), 64'd0);
      chk($sformatf("rst%0d out5", s), 64'(out5), 64'd0);
      seen = 1'b0;
      repeat (6) begin @(posedge clk); @(negedge clk); if (valid8) seen = 1'b1; end
      chk($sformatf("rst%0d no valid", s), 64'(seen), 64'd0);
    end
    do_op("post-rst", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0,
          16'h3C00, 16'h4000, 1'b0);

    // reset wins over a simultaneous start
    rst = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst+start busy", 64'(busy8), 64'd0);
    seen = 1'b0;
    repeat (6) begin @(posedge clk); @(negedge clk); if (valid8 || busy8) seen = 1'b1; end
    chk("rst+start quiet", 64'(seen), 64'd0);

    for (int n = 0; n < 400; n++) begin
      ra  = rnd_fp(8, 23);
      rb  = rnd_pair(8, 23, ra);
      rop = 1'($urandom);
      model(8, 23, ra, rb, rop, e8, eo, ei);
      x5  = rnd_fp(5, 10);
      do_op($sformatf("rnd%0d", n), ra, rb, rop, e8, eo, ei,
            x5[15:0], 16'(rnd_pair(5, 10, x5)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
